// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencing FSM for the RISC datapath.
// It accepts one decoded instruction per start strobe and steps the
// register file, the A/B/C pipeline registers, the status register and
// the ALU through read, execute and writeback.
// Optional feature macro: ALU_SEQ_HALT_EN (opcode 111 parks the FSM in HALT
// until reset; without it opcode 111 is treated as undefined).
module alu_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic [1:0] ALUop,
  output logic       err,
  output logic       halted
);

  typedef enum logic [3:0] {
    ST_WAIT      = 4'd0,
    ST_DECODE    = 4'd1,
    ST_WRITE_IMM = 4'd2,
    ST_GET_A     = 4'd3,
    ST_GET_B     = 4'd4,
    ST_EXEC      = 4'd5,
    ST_CMP_S     = 4'd6,
    ST_WRITE_REG = 4'd7,
    ST_HALT      = 4'd8
  } state_t;

  // Register-select encodings
  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  // Writeback source encodings
  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b10;

  // Opcode groups
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  state_t     state;
  state_t     state_nx;
  logic [2:0] opc_q;
  logic [1:0] op_q;

  logic is_mov_imm;
  logic is_mov_reg;
  logic is_mvn;
  logic is_alu_ab;
  logic is_cmp;
  logic is_halt;
  logic [1:0] alu_op_held;

  // Instruction classification from the captured fields only, so that
  // decoder inputs changing mid-instruction cannot disturb the sequence.
  assign is_mov_imm = (opc_q == OPC_MOV) && (op_q == 2'b10);
  assign is_mov_reg = (opc_q == OPC_MOV) && (op_q == 2'b00);
  assign is_mvn     = (opc_q == OPC_ALU) && (op_q == 2'b11);
  assign is_alu_ab  = (opc_q == OPC_ALU) && (op_q != 2'b11);
  assign is_cmp     = (opc_q == OPC_ALU) && (op_q == 2'b01);
`ifdef ALU_SEQ_HALT_EN
  assign is_halt    = (opc_q == OPC_HALT);
`else
  assign is_halt    = 1'b0;
`endif

  // ALU operation for the instruction in flight: the sub-op for ALU-group
  // instructions, plain add (pass-through) for moves.
  assign alu_op_held = (opc_q == OPC_ALU) ? op_q : 2'b00;

  // State register; reset drops straight back to WAIT, aborting any write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_WAIT;
    end else begin
      state <= state_nx;
    end
  end

  // Capture opcode/op when a start strobe is accepted in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_q <= 3'b000;
      op_q  <= 2'b00;
    end else if ((state == ST_WAIT) && s) begin
      opc_q <= opcode;
      op_q  <= op;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_WAIT: begin
        if (s) begin
          state_nx = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_mov_imm) begin
          state_nx = ST_WRITE_IMM;
        end else if (is_mov_reg || is_mvn) begin
          state_nx = ST_GET_B;
        end else if (is_alu_ab) begin
          state_nx = ST_GET_A;
        end else if (is_halt) begin
          state_nx = ST_HALT;
        end else begin
          state_nx = ST_WAIT;
        end
      end
      ST_WRITE_IMM: state_nx = ST_WAIT;
      ST_GET_A:     state_nx = ST_GET_B;
      ST_GET_B:     state_nx = is_cmp ? ST_CMP_S : ST_EXEC;
      ST_EXEC:      state_nx = ST_WRITE_REG;
      ST_CMP_S:     state_nx = ST_WAIT;
      ST_WRITE_REG: state_nx = ST_WAIT;
      ST_HALT: begin
`ifdef ALU_SEQ_HALT_EN
        state_nx = ST_HALT;
`else
        state_nx = ST_WAIT;
`endif
      end
      default:      state_nx = ST_WAIT;
    endcase
  end

  // Moore output decode: every strobe defaults low, each state raises
  // only the strobes it owns.
  always_comb begin
    w     = 1'b0;
    nsel  = NSEL_NONE;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    vsel  = VSEL_C;
    write = 1'b0;
    ALUop = 2'b00;
    err   = 1'b0;
    case (state)
      ST_WAIT: begin
        w = 1'b1;
      end
      ST_DECODE: begin
        ALUop = alu_op_held;
        err   = ~(is_mov_imm | is_mov_reg | is_mvn | is_alu_ab | is_halt);
      end
      ST_WRITE_IMM: begin
        ALUop = alu_op_held;
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM8;
        write = 1'b1;
      end
      ST_GET_A: begin
        ALUop = alu_op_held;
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      ST_GET_B: begin
        ALUop = alu_op_held;
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      ST_EXEC: begin
        ALUop = alu_op_held;
        loadc = 1'b1;
        asel  = is_mov_reg;
      end
      ST_CMP_S: begin
        ALUop = alu_op_held;
        loads = 1'b1;
      end
      ST_WRITE_REG: begin
        ALUop = alu_op_held;
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      default: begin
        w = 1'b0;
      end
    endcase
  end

  // Halt indicator exists only when the halt feature is built in.
`ifdef ALU_SEQ_HALT_EN
  assign halted = (state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed self-checking bench for alu_seq_ctrl.
// Honours the ALU_SEQ_HALT_EN macro the same way as the design.
module tb_alu_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic       loada, loadb, loadc, loads;
  logic       asel, bsel;
  logic [1:0] vsel;
  logic       write;
  logic [1:0] ALUop;
  logic       err;
  logic       halted;

  int checks   = 0;
  int failures = 0;
  int lowCount;

  logic [16:0] outs;

  alu_seq_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s      (s),
    .opcode (opcode),
    .op     (op),
    .w      (w),
    .nsel   (nsel),
    .loada  (loada),
    .loadb  (loadb),
    .loadc  (loadc),
    .loads  (loads),
    .asel   (asel),
    .bsel   (bsel),
    .vsel   (vsel),
    .write  (write),
    .ALUop  (ALUop),
    .err    (err),
    .halted (halted)
  );

  assign outs = {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, ALUop, err, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack an expected output vector in the same order as outs.
  function automatic logic [16:0] mk(input logic ew, input logic [2:0] ensel,
                                     input logic la, input logic lb, input logic lc,
                                     input logic ls, input logic ea, input logic eb,
                                     input logic [1:0] ev, input logic ewr,
                                     input logic [1:0] alu, input logic ee, input logic eh);
    return {ew, ensel, la, lb, lc, ls, ea, eb, ev, ewr, alu, ee, eh};
  endfunction

  task automatic checkOutput(input string tag, input logic [16:0] observed, input logic [16:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic es, input logic [2:0] eopc, input logic [1:0] eop);
    s      = es;
    opcode = eopc;
    op     = eop;
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [16:0] idle;

  initial begin
    idle = mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
    rst_n = 1'b0;
    applyStimulus(0, 3'b000, 2'b00);
    #2;
    checkOutput("reset_state", outs, idle);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("idle_after_reset", outs, idle);

    // MOV imm 110/10
    applyStimulus(1, 3'b110, 2'b10);
    step();
    applyStimulus(0, 3'b000, 2'b00);
    checkOutput("movi_decode", outs, mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    step();
    checkOutput("movi_write_imm", outs, mk(0, 3'b001, 0, 0, 0, 0, 0, 0, 2'b10, 1, 2'b00, 0, 0));
    step();
    checkOutput("movi_back_wait", outs, idle);

    // ADD 101/00
    applyStimulus(1, 3'b101, 2'b00);
    step();
    applyStimulus(0, 3'b000, 2'b00);
    checkOutput("add_decode", outs, mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    step();
    checkOutput("add_get_a", outs, mk(0, 3'b001, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    step();
    checkOutput("add_get_b", outs, mk(0, 3'b100, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    step();
    checkOutput("add_exec", outs, mk(0, 3'b000, 0, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    step();
    checkOutput("add_write_reg", outs, mk(0, 3'b010, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0));
    step();
    checkOutput("add_back_wait", outs, idle);

    // CMP 101/01: ALUop 01 throughout, loads in 4th cycle, no write
    applyStimulus(1, 3'b101, 2'b01);
    step();
    applyStimulus(0, 3'b000, 2'b00);
    checkOutput("cmp_decode", outs, mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 0));
    step();
    checkOutput("cmp_get_a", outs, mk(0, 3'b001, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 0));
    step();
    checkOutput("cmp_get_b", outs, mk(0, 3'b100, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 0));
    step();
    checkOutput("cmp_status", outs, mk(0, 3'b000, 0, 0, 0, 1, 0, 0, 2'b00, 0, 2'b01, 0, 0));
    step();
    checkOutput("cmp_back_wait_aluop0", outs, idle);

    // MOV reg 110/00, inputs changed after capture
    applyStimulus(1, 3'b110, 2'b00);
    step();
    applyStimulus(0, 3'b101, 2'b11);
    checkOutput("movr_decode", outs, mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    step();
    checkOutput("movr_get_b", outs, mk(0, 3'b100, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    step();
    checkOutput("movr_exec_asel", outs, mk(0, 3'b000, 0, 0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));
    step();
    checkOutput("movr_write_reg", outs, mk(0, 3'b010, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0));
    step();
    checkOutput("movr_back_wait", outs, idle);

    // MVN 101/11
    applyStimulus(1, 3'b101, 2'b11);
    step();
    applyStimulus(0, 3'b000, 2'b00);
    checkOutput("mvn_decode", outs, mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 0, 0));
    step();
    checkOutput("mvn_get_b", outs, mk(0, 3'b100, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b11, 0, 0));
    step();
    checkOutput("mvn_exec", outs, mk(0, 3'b000, 0, 0, 1, 0, 0, 0, 2'b00, 0, 2'b11, 0, 0));
    step();
    checkOutput("mvn_write_reg", outs, mk(0, 3'b010, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b11, 0, 0));
    step();

    // AND 101/10: count cycles with w low (bounded)
    applyStimulus(1, 3'b101, 2'b10);
    step();
    applyStimulus(0, 3'b000, 2'b00);
    lowCount = 0;
    while (w == 1'b0 && lowCount < 20) begin
      lowCount++;
      step();
    end
    checkOutput("and_w_low_cycles", 17'(lowCount), 17'd5);

    // Undefined 100/00
    applyStimulus(1, 3'b100, 2'b00);
    step();
    applyStimulus(0, 3'b000, 2'b00);
    checkOutput("undef_err", outs, mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 0));
    step();
    checkOutput("undef_back_wait", outs, idle);

    // Back-to-back MOV imm with s held high
    applyStimulus(1, 3'b110, 2'b10);
    step();
    step();
    checkOutput("b2b_write_imm", outs, mk(0, 3'b001, 0, 0, 0, 0, 0, 0, 2'b10, 1, 2'b00, 0, 0));
    step();
    checkOutput("b2b_wait", outs, idle);
    step();
    applyStimulus(0, 3'b000, 2'b00);
    checkOutput("b2b_second_decode", outs, mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    step();
    step();
    checkOutput("b2b_done", outs, idle);

    // Opcode 111
    applyStimulus(1, 3'b111, 2'b00);
    step();
    applyStimulus(0, 3'b000, 2'b00);
`ifdef ALU_SEQ_HALT_EN
    checkOutput("halt_decode", outs, mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    step();
    checkOutput("halt_state", outs, mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1));
    applyStimulus(1, 3'b110, 2'b10);
    step();
    step();
    checkOutput("halt_ignores_s", outs, mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1));
    applyStimulus(0, 3'b000, 2'b00);
    rst_n = 1'b0;
    #1;
    checkOutput("halt_reset_exit", outs, idle);
    step();
    rst_n = 1'b1;
    step();
`else
    checkOutput("op111_err", outs, mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 0));
    step();
    checkOutput("op111_back_wait", outs, idle);
`endif

    // Reset during GET_B of an ADD
    applyStimulus(1, 3'b101, 2'b00);
    step();
    applyStimulus(0, 3'b000, 2'b00);
    step();
    step();
    checkOutput("rst_mid_get_b", outs, mk(0, 3'b100, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_immediate", outs, idle);
    step();
    checkOutput("rst_mid_held", outs, idle);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rst_mid_no_write", outs, idle);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
